lsu: RTL and testbench

Load/store unit for the multi-cycle RV32I core: the memory stage that sits between execute and write-back. On a `start` pulse it takes the effective address (ALU result) and store data (rs2 value), runs one word-aligned transaction on a valid/ready data bus, and returns a sign- or zero-extended `load_result` to the register file for the write-back state. It also reports misaligned, illegal-width and bus-timeout faults instead of touching memory.

---
 rtl/lsu.sv | 207 ++++++++++++++++++++
 tb/tb_lsu.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu - load/store unit for the multi-cycle RV32I core (memory stage).
//
// Takes the effective address and store data on a start pulse, runs one
// word-aligned valid/ready bus transaction and returns extended load data.
// Misaligned accesses, illegal widths and bus timeouts are reported as
// faults. Misaligned and illegal-width accesses never reach the bus.
//
// Ports
//   clk_i, rst_i            core clock, async active-high reset
//   start_i                 one-cycle pulse, samples is_load/is_store/funct3/addr/store_data
//   load_result_o           extended load data, held until the next successful load
//   done_o                  one-cycle completion pulse
//   fault_o, fault_code_o   valid with done_o (01 misaligned, 10 width, 11 timeout)
//   busy_o                  high whenever the unit is not idle
//   mem_*                   data bus: request channel (valid/ready) + read response
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_result_o,
    output logic        done_o,
    output logic        fault_o,
    output logic [1:0]  fault_code_o,
    output logic        busy_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_WIDTH    = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;

    state_t      state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] tmo_cnt_q;
    logic [31:0] load_result_q;
    logic        done_q, fault_q, busy_q, valid_q, we_q;
    logic [1:0]  fault_code_q;
    logic [31:0] mem_addr_q, wdata_q;
    logic [3:0]  wstrb_q;

    // Decode of the incoming operation, consumed only in IDLE on start.
    logic        illegal_d, misalign_d;
    logic [31:0] wdata_d;
    logic [3:0]  wstrb_d;

    always_comb begin
        // Loads reject 011/11x; stores accept only 000/001/010.
        if (is_load_i)
            illegal_d = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
        else
            illegal_d = funct3_i[2] || (funct3_i[1:0] == 2'b11);
        misalign_d = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        wdata_d = store_data_i;
        wstrb_d = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                wdata_d = {4{store_data_i[7:0]}};
                wstrb_d = 4'b0001 << addr_i[1:0];
            end
            2'b01: begin
                wdata_d = {2{store_data_i[15:0]}};
                wstrb_d = addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Load extraction from the returned word using the latched byte offset.
    logic [31:0] shifted_d, load_ext_d;

    always_comb begin
        shifted_d = mem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
            3'b100:  load_ext_d = {24'h0, shifted_d[7:0]};
            3'b001:  load_ext_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
            3'b101:  load_ext_d = {16'h0, shifted_d[15:0]};
            default: load_ext_d = mem_rdata_i;
        endcase
    end

    // Timeout fires at the end of the TIMEOUT_CYCLES-th cycle in REQ/WAIT.
    logic tmo_hit;
    assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                     ((tmo_cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
            tmo_cnt_q     <= 32'h0;
            load_result_q <= 32'h0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= 2'b00;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
            we_q          <= 1'b0;
            mem_addr_q    <= 32'h0;
            wdata_q       <= 32'h0;
            wstrb_q       <= 4'b0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        funct3_q   <= funct3_i;
                        off_q      <= addr_i[1:0];
                        tmo_cnt_q  <= 32'h0;
                        busy_q     <= 1'b1;
                        mem_addr_q <= {addr_i[31:2], 2'b00};
                        we_q       <= !is_load_i;
                        wdata_q    <= is_load_i ? 32'h0 : wdata_d;
                        wstrb_q    <= is_load_i ? 4'b0000 : wstrb_d;
                        if (!is_load_i && !is_store_i) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (illegal_d) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            fault_q      <= 1'b1;
                            fault_code_q <= FC_WIDTH;
                        end else if (misalign_d) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            fault_q      <= 1'b1;
                            fault_code_q <= FC_MISALIGN;
                        end else begin
                            state_q <= S_REQ;
                            valid_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    // Acceptance wins over a timeout landing in the same cycle.
                    if (mem_req_ready_i) begin
                        valid_q <= 1'b0;
                        if (we_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else if (tmo_hit) begin
                        valid_q      <= 1'b0;
                        state_q      <= S_DONE;
                        done_q       <= 1'b1;
                        fault_q      <= 1'b1;
                        fault_code_q <= FC_TIMEOUT;
                    end
                end
                S_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    if (mem_rsp_valid_i) begin
                        load_result_q <= load_ext_d;
                        state_q       <= S_DONE;
                        done_q        <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q      <= S_DONE;
                        done_q       <= 1'b1;
                        fault_q      <= 1'b1;
                        fault_code_q <= FC_TIMEOUT;
                    end
                end
                S_DONE: begin
                    state_q      <= S_IDLE;
                    done_q       <= 1'b0;
                    fault_q      <= 1'b0;
                    fault_code_q <= 2'b00;
                    busy_q       <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign load_result_o   = load_result_q;
    assign done_o          = done_q;
    assign fault_o         = fault_q;
    assign fault_code_o    = fault_code_q;
    assign busy_o          = busy_q;
    assign mem_req_valid_o = valid_q;
    assign mem_we_o        = we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = wdata_q;
    assign mem_wstrb_o     = wstrb_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, is_load = 1'b0, is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0, store_data = 32'h0;
    logic [31:0] load_result;
    logic        done, fault, busy;
    logic [1:0]  fault_code;
    logic        mem_req_valid, mem_we;
    logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;
    logic [3:0]  mem_wstrb;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .is_load_i(is_load), .is_store_i(is_store), .funct3_i(funct3),
        .addr_i(addr), .store_data_i(store_data),
        .load_result_o(load_result), .done_o(done), .fault_o(fault),
        .fault_code_o(fault_code), .busy_o(busy),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb), .mem_rsp_valid_i(mem_rsp_valid),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        flt;
        logic [1:0]  code;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_good = 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] r, input logic f, input logic [1:0] c);
        exp_t e;
        e.res = r; e.flt = f; e.code = c;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd);
        is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Load with zero-wait ready and response: done expected at N+3.
    task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] expv);
        exp_t e;
        push_exp(expv, 1'b0, 2'b00);
        do_start(1'b1, 1'b0, f3, a, 32'h0);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== {a[31:2], 2'b00} || mem_wstrb !== 4'b0000 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL %s_req: valid=%b addr=%h wstrb=%b we=%b required 1 %h 0000 0", nm, mem_req_valid, mem_addr, mem_wstrb, mem_we, {a[31:2], 2'b00});
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_wait: valid=%b done=%b busy=%b required 0 0 1", nm, mem_req_valid, done, busy);
        end
        mem_rsp_valid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rsp_valid = 1'b0; mem_rdata = 32'hA5A5A5A5;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_latency: done=%b required 1 at N+3", nm, done);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (load_result !== e.res || fault !== e.flt || fault_code !== e.code) begin
                failures++;
                $display("FAIL %s_result: got %h/%b/%b required %h/%b/%b", nm, load_result, fault, fault_code, e.res, e.flt, e.code);
            end
        end
        last_good = expv;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || fault_code !== 2'b00) begin
            failures++;
            $display("FAIL %s_after: done=%b busy=%b code=%b required 0 0 00", nm, done, busy, fault_code);
        end
    endtask

    // Store with nwait cycles of ready low; request must hold steady meanwhile.
    task automatic do_store(input string nm, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] exp_wd,
                            input logic [3:0] exp_ws, input int nwait);
        exp_t e;
        push_exp(last_good, 1'b0, 2'b00);
        do_start(1'b0, 1'b1, f3, a, sd);
        for (int i = 0; i <= nwait; i++) begin
            if (i == nwait) mem_req_ready = 1'b1;
            checks++;
            if (mem_req_valid !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== exp_wd || mem_wstrb !== exp_ws ||
                mem_addr !== {a[31:2], 2'b00} || done !== 1'b0) begin
                failures++;
                $display("FAIL %s_req%0d: valid=%b we=%b wdata=%h wstrb=%b addr=%h done=%b required 1 1 %h %b %h 0",
                         nm, i, mem_req_valid, mem_we, mem_wdata, mem_wstrb, mem_addr, done, exp_wd, exp_ws, {a[31:2], 2'b00});
            end
            tick();
        end
        mem_req_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: done=%b valid=%b required 1 0", nm, done, mem_req_valid);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (load_result !== e.res || fault !== e.flt || fault_code !== e.code) begin
                failures++;
                $display("FAIL %s_status: got %h/%b/%b required %h/%b/%b", nm, load_result, fault, fault_code, e.res, e.flt, e.code);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_after: done=%b busy=%b required 0 0", nm, done, busy);
        end
    endtask

    // Faulting or no-op operation: done at N+1 without a bus request.
    task automatic do_quick(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic ef, input logic [1:0] ec);
        exp_t e;
        push_exp(last_good, ef, ec);
        do_start(ld, st, f3, a, 32'hCAFEF00D);
        checks++;
        if (done !== 1'b1 || mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_timing: done=%b valid=%b required 1 0", nm, done, mem_req_valid);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (load_result !== e.res || fault !== e.flt || fault_code !== e.code) begin
                failures++;
                $display("FAIL %s_status: got %h/%b/%b required %h/%b/%b", nm, load_result, fault, fault_code, e.res, e.flt, e.code);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || fault_code !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_after: done=%b code=%b busy=%b required 0 00 0", nm, done, fault_code, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (load_result !== 32'h0 || done !== 1'b0 || fault !== 1'b0 || fault_code !== 2'b00 || busy !== 1'b0 ||
            mem_req_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state: res=%h done=%b flt=%b code=%b busy=%b valid=%b we=%b addr=%h wdata=%h wstrb=%b required all zero",
                     load_result, done, fault, fault_code, busy, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
        rst = 1'b0;
        last_good = 32'h0;
        tick();
    endtask

    task automatic test_loads();
        do_load("lw",  3'b010, 32'h0000_0100, 32'hDEADBEEF, 32'hDEADBEEF);
        do_load("lb",  3'b000, 32'h0000_0103, 32'h80FF7F01, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF7F01, 32'h00000080);
        do_load("lh",  3'b001, 32'h0000_0102, 32'h80FF7F01, 32'hFFFF80FF);
        do_load("lhu", 3'b101, 32'h0000_0100, 32'h80FF7F01, 32'h00007F01);
        do_load("lb1", 3'b000, 32'h0000_0101, 32'h80FF7F01, 32'h0000007F);
    endtask

    task automatic test_stores();
        do_store("sb",   3'b000, 32'h0000_0201, 32'h12345678, 32'h78787878, 4'b0010, 0);
        do_store("sh",   3'b001, 32'h0000_0202, 32'h12345678, 32'h56785678, 4'b1100, 3);
        do_store("sh0",  3'b001, 32'h0000_0200, 32'h12345678, 32'h56785678, 4'b0011, 1);
        do_store("sw",   3'b010, 32'h0000_0204, 32'h12345678, 32'h12345678, 4'b1111, 0);
    endtask

    task automatic test_faults();
        do_quick("lw_mis",   1'b1, 1'b0, 3'b010, 32'h0000_0102, 1'b1, 2'b01);
        do_quick("ld_f3_11", 1'b1, 1'b0, 3'b011, 32'h0000_0100, 1'b1, 2'b10);
        do_quick("lh_mis",   1'b1, 1'b0, 3'b001, 32'h0000_0101, 1'b1, 2'b01);
        do_quick("st_f3_4",  1'b0, 1'b1, 3'b100, 32'h0000_0100, 1'b1, 2'b10);
        do_quick("sw_mis",   1'b0, 1'b1, 3'b010, 32'h0000_0203, 1'b1, 2'b01);
        do_quick("noop",     1'b0, 1'b0, 3'b010, 32'h0000_0103, 1'b0, 2'b00);
    endtask

    // Ready never asserted: 4 cycles in REQ, then timeout; a start pulse
    // while busy carries an illegal op that would show up if accepted.
    task automatic test_timeout();
        exp_t e;
        push_exp(last_good, 1'b1, 2'b11);
        do_start(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL tmo_req%0d: valid=%b done=%b required 1 0", i, mem_req_valid, done);
            end
            if (i == 2) begin
                is_load = 1'b1; funct3 = 3'b011; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL tmo_done: done=%b valid=%b required 1 0", done, mem_req_valid);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (load_result !== e.res || fault !== e.flt || fault_code !== e.code) begin
                failures++;
                $display("FAIL tmo_status: got %h/%b/%b required %h/%b/%b", load_result, fault, fault_code, e.res, e.flt, e.code);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL tmo_idle%0d: done=%b busy=%b required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Reset while in REQ: valid must drop before the next clock edge.
        do_start(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_req: valid=%b busy=%b done=%b required 0 0 0", mem_req_valid, busy, done);
        end
        tick();
        rst = 1'b0;
        tick();
        // Reset while in WAIT, then a stale response.
        do_start(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_pre_wait: busy=%b valid=%b required 1 0", busy, mem_req_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_result !== 32'h0) begin
            failures++;
            $display("FAIL rst_wait: valid=%b busy=%b done=%b res=%h required 0 0 0 0", mem_req_valid, busy, done, load_result);
        end
        tick();
        rst = 1'b0;
        last_good = 32'h0;
        mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || load_result !== 32'h0) begin
                failures++;
                $display("FAIL rst_stale%0d: done=%b busy=%b res=%h required 0 0 0", i, done, busy, load_result);
            end
            tick();
        end
        do_load("lw_post_rst", 3'b010, 32'h0000_0500, 32'h0BADF00D, 32'h0BADF00D);
    endtask

    task automatic test_back_to_back();
        do_load("b2b_lw", 3'b010, 32'h0000_0600, 32'h11223344, 32'h11223344);
        do_store("b2b_sb", 3'b000, 32'h0000_0603, 32'h000000AB, 32'hABABABAB, 4'b1000, 0);
        do_load("b2b_lhu", 3'b101, 32'h0000_0602, 32'h9ABC1234, 32'h00009ABC);
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
